// File: rtl/stage_advance.sv
// stage_advance: counts player hits and, once the stage target is met,
// pulses nextStage to the stage shift register, or sets gameClear after the last stage.
module stage_advance #(
   parameter int BASE_HITS    = 3,
   parameter int STEP_HITS    = 1,
   parameter int PULSE_CYCLES = 2,
   parameter int HOLD_CYCLES  = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       hit,
   input  logic [4:0] stageIn,
   output logic       nextStage,
   output logic [3:0] hitCount,
   output logic [2:0] level,
   output logic       playing,
   output logic       gameClear
);

   typedef enum logic [2:0] {
      IDLE,
      PLAY,
      PULSE,
      HOLD,
      CLEAR
   } state_t;

   localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
   localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] hits_q, hits_d;
   logic       ns_q, ns_d;
   logic       gc_q, gc_d;
   logic       play_q, play_d;
   logic       prev_q;

   logic       hit_edge;
   logic [4:0] sum;
   logic [4:0] target;
   logic [4:0] n;

   assign hit_edge = hit & ~prev_q;
   assign n        = {1'b0, hits_q} + 5'd1;

   // Level is the run of ones from stageIn[0] up to the first zero.
   always_comb begin
      level = 3'd0;
      unique casez (stageIn)
         5'b????0: level = 3'd0;
         5'b???01: level = 3'd1;
         5'b??011: level = 3'd2;
         5'b?0111: level = 3'd3;
         5'b01111: level = 3'd4;
         5'b11111: level = 3'd5;
         default:  level = 3'd0;
      endcase
   end

   // Per-stage hit target, 5-bit sum saturated to the 4-bit counter range.
   always_comb begin
      sum    = 5'(BASE_HITS + STEP_HITS * int'(level));
      target = (sum > 5'd15) ? 5'd15 : sum;
   end

   // Next-state and registered-output logic for the game FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hits_d  = hits_q;
      ns_d    = ns_q;
      gc_d    = gc_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = PLAY;
               hits_d  = 4'd0;
            end
         end
         PLAY: begin
            if (hit_edge) begin
               if (n < target) begin
                  hits_d = n[3:0];
               end else if (level < 3'd5) begin
                  state_d = PULSE;
                  hits_d  = 4'd0;
                  ns_d    = 1'b1;
                  cnt_d   = PULSE_LD;
               end else begin
                  state_d = CLEAR;
                  hits_d  = 4'd0;
                  gc_d    = 1'b1;
               end
            end
         end
         PULSE: begin
            if (cnt_q == 8'd0) begin
               state_d = HOLD;
               ns_d    = 1'b0;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         HOLD: begin
            if (cnt_q == 8'd0) begin
               state_d = PLAY;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         CLEAR: begin
            state_d = CLEAR;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      play_d = (state_d == PLAY) || (state_d == PULSE) || (state_d == HOLD);
   end

   // State and output registers; reset clears everything at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         hits_q  <= 4'd0;
         ns_q    <= 1'b0;
         gc_q    <= 1'b0;
         play_q  <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hits_q  <= hits_d;
         ns_q    <= ns_d;
         gc_q    <= gc_d;
         play_q  <= play_d;
         prev_q  <= hit;
      end
   end

   assign nextStage = ns_q;
   assign hitCount  = hits_q;
   assign playing   = play_q;
   assign gameClear = gc_q;

endmodule

// File: tb/tb_stage_advance.sv
// tb_stage_advance: stage_advance with a stageOn shift register attached,
// compared every cycle against a timeline model of the game rules.
module tb_stage_advance;

   localparam int P = 2;
   localparam int H = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       hit;
   logic       frc;
   logic [4:0] frc_v;
   logic [4:0] so_q;
   logic [4:0] stageIn;
   logic       nextStage;
   logic [3:0] hitCount;
   logic [2:0] level;
   logic       playing;
   logic       gameClear;

   int checks = 0;
   int errors = 0;
   int npulse = 0;

   stage_advance dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .hit      (hit),
      .stageIn  (stageIn),
      .nextStage(nextStage),
      .hitCount (hitCount),
      .level    (level),
      .playing  (playing),
      .gameClear(gameClear)
   );

   always #5 clock = ~clock;

   // stageOn: thermometer shift on each nextStage rising edge.
   always @(posedge nextStage or posedge reset) begin
      if (reset) so_q <= 5'd0;
      else       so_q <= {so_q[3:0], 1'b1};
   end

   assign stageIn = frc ? frc_v : so_q;

   initial forever begin
      @(posedge nextStage);
      npulse++;
   end

   function automatic int lvl_of(input logic [4:0] s);
      int c = 0;
      for (int i = 0; i < 5 && s[i] === 1'b1; i++) c++;
      return c;
   endfunction

   function automatic int tgt(input int l);
      int t = 3 + l;
      return (t > 15) ? 15 : t;
   endfunction

   // Model: mode 0 idle, 1 in game, 2 cleared; pulses tracked by edge index.
   int m_mode, m_cnt, m_k, m_ps, m_l;
   bit m_pend, m_prev, m_clr, m_e;

   initial begin
      m_mode = 0; m_cnt = 0; m_k = 0; m_ps = 0;
      m_pend = 0; m_prev = 0; m_clr = 0;
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            m_mode = 0; m_cnt = 0; m_k = 0; m_ps = 0;
            m_pend = 0; m_prev = 0; m_clr = 0;
         end else begin
            m_k++;
            m_e = hit && !m_prev;
            m_l = lvl_of(stageIn);
            if (m_mode == 0) begin
               if (start) begin
                  m_mode = 1; m_cnt = 0; m_pend = 0;
               end
            end else if (m_mode == 1) begin
               if (m_e && (!m_pend || m_k >= m_ps + P + H + 1)) begin
                  if (m_cnt + 1 < tgt(m_l)) begin
                     m_cnt++;
                  end else if (m_l < 5) begin
                     m_cnt = 0; m_pend = 1; m_ps = m_k;
                  end else begin
                     m_cnt = 0; m_mode = 2; m_clr = 1;
                  end
               end
            end
            m_prev = hit;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clock);
      chk("m_nextStage", int'(nextStage),
          int'(m_mode == 1 && m_pend && (m_k - m_ps) < P));
      chk("m_hitCount", int'(hitCount), m_cnt);
      chk("m_playing", int'(playing), int'(m_mode == 1));
      chk("m_gameClear", int'(gameClear), int'(m_clr));
      chk("m_level", int'(level), lvl_of(stageIn));
   end

   task automatic step(input bit h, input bit s);
      @(negedge clock);
      #1;
      hit   = h;
      start = s;
   endtask

   task automatic do_reset();
      @(negedge clock);
      #1;
      reset = 1'b1; hit = 1'b0; start = 1'b0;
      repeat (2) step(0, 0);
      reset = 1'b0;
   endtask

   task automatic tap(input int k);
      for (int i = 0; i < k; i++) begin
         step(1, 0);
         step(0, 0);
      end
   endtask

   int n;
   int nh;

   initial begin
      reset = 1'b1; start = 1'b0; hit = 1'b0;
      frc = 1'b0; frc_v = 5'd0;
      repeat (3) step(0, 0);
      chk("rst_outputs", int'({nextStage, hitCount, level, playing, gameClear}), 0);
      reset = 1'b0;
      tap(3);
      chk("idle_hitCount", int'(hitCount), 0);
      chk("idle_playing", int'(playing), 0);

      step(0, 1);
      step(0, 0);
      chk("start_playing", int'(playing), 1);
      tap(1);
      chk("l0_hc1", int'(hitCount), 1);
      tap(1);
      chk("l0_hc2", int'(hitCount), 2);
      tap(1);
      chk("l0_hc0", int'(hitCount), 0);
      chk("l0_ns_rise", int'(nextStage), 1);
      n = 1;
      while (nextStage && n < 20) begin
         step(0, 0);
         if (nextStage) n++;
      end
      chk("l0_ns_width", n, P);
      chk("l0_level", int'(level), 1);

      repeat (6) step(0, 0);
      repeat (10) step(1, 0);
      step(0, 0);
      chk("held_hit_once", int'(hitCount), 1);
      tap(3);
      chk("l1_pulse", int'(nextStage), 1);
      tap(3);
      chk("cooldown_ignored", int'(hitCount), 0);
      tap(1);
      chk("after_hold_counts", int'(hitCount), 1);

      do_reset();
      step(0, 1);
      nh = 0;
      while (!gameClear && nh < 100) begin
         tap(1);
         nh++;
         if (nextStage) repeat (6) step(0, 0);
      end
      chk("game_hits", nh, 33);
      chk("game_pulses", npulse - 2, 5);
      chk("game_stage", int'(stageIn), 31);
      chk("game_clear", int'(gameClear), 1);
      for (int i = 0; i < 20; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("clear_no_pulse", npulse - 2, 5);
      chk("clear_playing", int'(playing), 0);

      do_reset();
      step(1, 1);
      step(0, 0);
      chk("start_hit_same", int'(hitCount), 0);
      frc_v = 5'b00101;
      frc = 1'b1;
      #1;
      chk("dec_00101", int'(level), 1);
      tap(3);
      chk("t4_hc3", int'(hitCount), 3);
      chk("t4_no_ns", int'(nextStage), 0);
      tap(1);
      chk("t4_ns", int'(nextStage), 1);
      repeat (6) step(0, 0);
      frc_v = 5'b11111;
      #1;
      chk("dec_11111", int'(level), 5);
      tap(7);
      chk("t8_hc7", int'(hitCount), 7);
      tap(1);
      chk("t8_clear", int'(gameClear), 1);
      chk("t8_no_ns", int'(nextStage), 0);
      frc = 1'b0;

      do_reset();
      step(0, 1);
      n = 0;
      while (!gameClear && n < 3000) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         n++;
      end
      chk("rand_clear", int'(gameClear), 1);

      do_reset();
      step(0, 1);
      tap(2);
      step(1, 0);
      @(posedge clock);
      #1;
      chk("mid_ns_high", int'(nextStage), 1);
      reset = 1'b1;
      #1;
      chk("mid_ns", int'(nextStage), 0);
      chk("mid_hc", int'(hitCount), 0);
      chk("mid_play", int'(playing), 0);
      chk("mid_level", int'(level), 0);
      step(0, 0);
      step(0, 0);
      reset = 1'b0;
      step(0, 1);
      step(0, 0);
      chk("resume_level", int'(level), 0);
      tap(3);
      chk("resume_pulse", int'(nextStage), 1);
      repeat (8) step(0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
